// File: rtl/shader_pkg.sv
// shader_pkg: shared types and constants for the shader instruction arbiter.
//   opcode_e    - legal shader opcodes (ADD/SUB/MUL/MAC)
//   arb_state_e - output-register FSM state (EMPTY/FULL)
//   OP_MAX      - largest legal opcode value; anything above is illegal
//   CNT_W       - width of the optional per-requester grant counters
package shader_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_MAC = 2'd3
    } opcode_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_e;

    localparam int OP_MAX = 3;
    localparam int CNT_W  = 16;

endpackage

// File: rtl/shader_rr_pick.sv
// shader_rr_pick: combinational round-robin picker.
//   req   [NUM_REQ] - request vector
//   ptr   [ID_W]    - index where the search starts (highest priority)
//   grant [NUM_REQ] - one-hot winner, zero when nothing requests
//   idx   [ID_W]    - winner index, zero when nothing requests
//   any             - at least one request present
module shader_rr_pick #(
    parameter int NUM_REQ = 4,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    // Walk offsets 0..NUM_REQ-1 from ptr with wrap; first hit wins.
    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/shader_instr_arb.sv
// shader_instr_arb: round-robin arbiter from NUM_REQ instruction requesters
// into a single one-entry output register facing the shader core.
//   clk, rst_n          - clock, asynchronous active-low reset
//   req_valid/ready     - per-requester handshake
//   req_opcode          - per-requester opcode (0 ADD, 1 SUB, 2 MUL, 3 MAC)
//   req_is_vector       - per-requester scalar(0)/vector(1)
//   core_valid/ready    - handshake toward the core
//   core_opcode, core_is_vector, core_src_id - held instruction
//   err_illegal         - one-cycle pulse after an opcode > OP_MAX is consumed
// Optional feature (macro SHADER_INSTR_ARB_STATS_EN):
//   cnt_clr             - synchronous clear of the grant counters
//   grant_cnt           - per-requester saturating count of core handshakes
module shader_instr_arb
    import shader_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int OPCODE_W = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ-1:0][OPCODE_W-1:0]   req_opcode,
    input  logic [NUM_REQ-1:0]                 req_is_vector,
    output logic                               core_valid,
    input  logic                               core_ready,
    output logic [OPCODE_W-1:0]                core_opcode,
    output logic                               core_is_vector,
    output logic [ID_W-1:0]                    core_src_id,
    output logic                               err_illegal
`ifdef SHADER_INSTR_ARB_STATS_EN
    ,
    input  logic                               cnt_clr,
    output logic [NUM_REQ-1:0][CNT_W-1:0]      grant_cnt
`endif
);

    arb_state_e           state;
    logic [ID_W-1:0]      rr_ptr;
    logic [NUM_REQ-1:0]   pick_grant;
    logic [ID_W-1:0]      pick_idx;
    logic                 pick_any;
    logic                 load_en;
    logic                 accept;
    logic                 legal;
    logic [OPCODE_W-1:0]  sel_opcode;
    logic [ID_W-1:0]      ptr_next;

    shader_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign core_valid = (state == ST_FULL);
    // The slot can take a new instruction when empty or when the current one
    // is leaving this cycle, which gives back-to-back throughput.
    assign load_en    = (state == ST_EMPTY) || (core_valid && core_ready);
    assign accept     = load_en && pick_any;
    assign req_ready  = accept ? pick_grant : '0;
    assign sel_opcode = req_opcode[pick_idx];
    assign legal      = (32'(sel_opcode) <= 32'(OP_MAX));
    assign ptr_next   = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + ID_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_EMPTY;
            rr_ptr         <= '0;
            core_opcode    <= '0;
            core_is_vector <= 1'b0;
            core_src_id    <= '0;
            err_illegal    <= 1'b0;
        end else begin
            // Illegal opcodes still consume the request and advance the pointer.
            err_illegal <= accept && !legal;
            if (accept) begin
                rr_ptr <= ptr_next;
            end
            case (state)
                ST_EMPTY: begin
                    if (accept && legal) begin
                        state          <= ST_FULL;
                        core_opcode    <= sel_opcode;
                        core_is_vector <= req_is_vector[pick_idx];
                        core_src_id    <= pick_idx;
                    end
                end
                ST_FULL: begin
                    if (core_ready) begin
                        if (accept && legal) begin
                            core_opcode    <= sel_opcode;
                            core_is_vector <= req_is_vector[pick_idx];
                            core_src_id    <= pick_idx;
                        end else begin
                            state <= ST_EMPTY;
                        end
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

`ifdef SHADER_INSTR_ARB_STATS_EN
    // Counts instructions actually handed to the core; clear wins over count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
        end else if (cnt_clr) begin
            grant_cnt <= '0;
        end else if (core_valid && core_ready && (grant_cnt[core_src_id] != '1)) begin
            grant_cnt[core_src_id] <= grant_cnt[core_src_id] + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_shader_instr_arb.sv
// Directed bench for shader_instr_arb (NUM_REQ=4, OPCODE_W=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled
// a further time unit later, well away from the next edge.
module tb_shader_instr_arb;

    localparam int NUM_REQ  = 4;
    localparam int OPCODE_W = 4;
    localparam int ID_W     = 2;

    logic                             clk;
    logic                             rst_n;
    logic [NUM_REQ-1:0]               req_valid;
    logic [NUM_REQ-1:0]               req_ready;
    logic [NUM_REQ-1:0][OPCODE_W-1:0] req_opcode;
    logic [NUM_REQ-1:0]               req_is_vector;
    logic                             core_valid;
    logic                             core_ready;
    logic [OPCODE_W-1:0]              core_opcode;
    logic                             core_is_vector;
    logic [ID_W-1:0]                  core_src_id;
    logic                             err_illegal;
`ifdef SHADER_INSTR_ARB_STATS_EN
    logic                             cnt_clr;
    logic [NUM_REQ-1:0][15:0]         grant_cnt;
`endif

    int tests = 0;
    int fails = 0;

    shader_instr_arb #(.NUM_REQ(NUM_REQ), .OPCODE_W(OPCODE_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_opcode     (req_opcode),
        .req_is_vector  (req_is_vector),
        .core_valid     (core_valid),
        .core_ready     (core_ready),
        .core_opcode    (core_opcode),
        .core_is_vector (core_is_vector),
        .core_src_id    (core_src_id),
        .err_illegal    (err_illegal)
`ifdef SHADER_INSTR_ARB_STATS_EN
        ,
        .cnt_clr        (cnt_clr),
        .grant_cnt      (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        req_valid     = '0;
        core_ready    = 1'b0;
        req_is_vector = 4'b1010;
        for (int i = 0; i < NUM_REQ; i++) req_opcode[i] = OPCODE_W'(i);
`ifdef SHADER_INSTR_ARB_STATS_EN
        cnt_clr = 1'b0;
`endif

        // Reset state
        #1;
        chk("rst_core_valid", 32'(core_valid), 0);
        chk("rst_core_opcode", 32'(core_opcode), 0);
        chk("rst_core_vec", 32'(core_is_vector), 0);
        chk("rst_src_id", 32'(core_src_id), 0);
        chk("rst_err", 32'(err_illegal), 0);
`ifdef SHADER_INSTR_ARB_STATS_EN
        chk("rst_cnt0", 32'(grant_cnt[0]), 0);
`endif
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", 32'(req_ready), 0);
        chk("post_rst_valid", 32'(core_valid), 0);

        // Rotation with full throughput: sources 0,1,2,3,0 back to back
        req_valid  = 4'b1111;
        core_ready = 1'b1;
        #1;
        chk("rot_first_ready", 32'(req_ready), 32'b0001);
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("rot_valid_%0d", k), 32'(core_valid), 1);
            chk($sformatf("rot_src_%0d", k), 32'(core_src_id), 32'(k % 4));
            chk($sformatf("rot_op_%0d", k), 32'(core_opcode), 32'(k % 4));
        end
        chk("rot_next_ready", 32'(req_ready), 32'b0010);
        req_valid = '0;
        step();
        chk("rot_drain_empty", 32'(core_valid), 0);   // rr_ptr now 1

        // Backpressure: req0 MAC vector held for 5 stalled cycles
        req_opcode[0]    = 4'd3;
        req_is_vector[0] = 1'b1;
        req_valid        = 4'b0001;
        core_ready       = 1'b0;
        #1;
        chk("bp_accept_ready", 32'(req_ready), 32'b0001);
        step();
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("bp_op_%0d", k), 32'(core_opcode), 3);
            chk($sformatf("bp_vec_%0d", k), 32'(core_is_vector), 1);
            chk($sformatf("bp_src_%0d", k), 32'(core_src_id), 0);
            chk($sformatf("bp_ready_%0d", k), 32'(req_ready), 0);
            step();
        end
        core_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'b0010);
        step();
        chk("bp_next_src", 32'(core_src_id), 1);
        chk("bp_next_op", 32'(core_opcode), 1);
        req_valid = '0;
        step();
        chk("bp_drain_empty", 32'(core_valid), 0);    // rr_ptr now 2

        // Illegal opcode from req2
        req_opcode[2] = 4'd9;
        req_valid     = 4'b0100;
        #1;
        chk("ill_ready", 32'(req_ready), 32'b0100);
        step();
        req_valid = '0;
        chk("ill_err_pulse", 32'(err_illegal), 1);
        chk("ill_not_fwd", 32'(core_valid), 0);
        req_opcode[2] = 4'd2;
        req_valid     = 4'b1111;
        #1;
        chk("ill_next_ready", 32'(req_ready), 32'b1000);
        step();
        chk("ill_err_clear", 32'(err_illegal), 0);
        chk("ill_next_src", 32'(core_src_id), 3);
        req_valid = '0;
        step();
        chk("ill_drain_empty", 32'(core_valid), 0);   // rr_ptr now 0

        // Sparse requests with wrap: bring rr_ptr to 2, then req3/req1 only
        req_valid = 4'b0010;
        step();
        chk("sp_pre_src", 32'(core_src_id), 1);
        req_valid = 4'b1010;
        #1;
        chk("sp_ready_3", 32'(req_ready), 32'b1000);
        step();
        chk("sp_src_3", 32'(core_src_id), 3);
        chk("sp_ready_1", 32'(req_ready), 32'b0010);
        step();
        chk("sp_src_1", 32'(core_src_id), 1);
        chk("sp_valid", 32'(core_valid), 1);
        req_valid = '0;
        step();
        chk("sp_drain_empty", 32'(core_valid), 0);

        // Reset while FULL: held instruction dropped immediately
        req_valid  = 4'b0001;
        core_ready = 1'b0;
        step();
        chk("mr_full", 32'(core_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_async_valid", 32'(core_valid), 0);
        chk("mr_async_opcode", 32'(core_opcode), 0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("mr_after_valid", 32'(core_valid), 0);
        req_valid  = 4'b1111;
        core_ready = 1'b1;
        #1;
        chk("mr_ptr_zero", 32'(req_ready), 32'b0001);
        req_valid = '0;
        step();

`ifdef SHADER_INSTR_ARB_STATS_EN
        // Three req0 handshakes then a clear that collides with a handshake
        chk("cnt_start", 32'(grant_cnt[0]), 0);
        req_valid = 4'b0001;
        step();
        step();
        step();
        req_valid = '0;
        step();
        chk("cnt_three", 32'(grant_cnt[0]), 3);
        chk("cnt_other", 32'(grant_cnt[1]), 0);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        cnt_clr   = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("cnt_clr_priority", 32'(grant_cnt[0]), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shader_instr_arb.md
SHADER_INSTR_ARB -- requirements
Module: shader_instr_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of instruction requesters (2..8).
REQ-002 SHALL have parameter OPCODE_W, default 4, opcode width.
REQ-003 SHALL have localparam ID_W = $clog2(NUM_REQ), requester index width.
REQ-004 SHALL have one clock and an asynchronous active-low reset: port clk (input, 1, clock) and port rst_n (input, 1, reset).
REQ-005 SHALL have port req_valid, input, NUM_REQ, per-requester instruction valid.
REQ-006 SHALL have port req_ready, output, NUM_REQ, per-requester accept.
REQ-007 SHALL have port req_opcode, input, NUM_REQ x OPCODE_W, per-requester opcode (0 ADD, 1 SUB, 2 MUL, 3 MAC).
REQ-008 SHALL have port req_is_vector, input, NUM_REQ, per-requester scalar(0)/vector(1).
REQ-009 SHALL have port core_valid, output, 1, instruction presented to the shader core.
REQ-010 SHALL have port core_ready, input, 1, core accepts the instruction.
REQ-011 SHALL have ports core_opcode (output, OPCODE_W) and core_is_vector (output, 1), the forwarded instruction.
REQ-012 SHALL have port core_src_id, output, ID_W, index of the originating requester.
REQ-013 SHALL have port err_illegal, output, 1, one-cycle pulse when an opcode > 3 is accepted.

Function
REQ-014 SHALL contain a one-entry output register with a two-state FSM: EMPTY (core_valid=0) and FULL (core_valid=1).
REQ-015 load_en SHALL be defined as (state==EMPTY) or (core_valid and core_ready); a new instruction can be accepted only when load_en=1.
REQ-016 Round-robin selection SHALL start at pointer rr_ptr and pick the first index i, searching ascending with wrap, that has req_valid[i]=1.
REQ-017 req_ready SHALL be one-hot on the selected index when load_en=1 and at least one request is valid; otherwise it SHALL be all zeros. It SHALL be combinational from req_valid, rr_ptr, state and core_ready.
REQ-018 On acceptance of a legal opcode at cycle N, core_valid/core_opcode/core_is_vector/core_src_id SHALL present the instruction at cycle N+1 (latency 1, throughput 1 per cycle under continuous core_ready).
REQ-019 On each acceptance, rr_ptr SHALL become (selected+1) mod NUM_REQ, with wrap from NUM_REQ-1 to 0.
REQ-020 While FULL and core_ready=0, the core_* outputs SHALL remain stable, and req_ready SHALL be all zeros.
REQ-021 When FULL, core_ready=1, and no request is valid, the FSM SHALL go to EMPTY next cycle.
REQ-022 When FULL, core_ready=1, and a request is valid, the FSM SHALL stay FULL, load the new instruction, and produce no bubble.
REQ-023 An accepted opcode > 3 SHALL be consumed (req_ready=1), SHALL NOT be forwarded, SHALL pulse err_illegal at cycle N+1, and SHALL advance rr_ptr. The FSM SHALL then behave as if no request was valid.
REQ-024 The block SHALL NOT respond to core_ready while EMPTY.
REQ-025 req_valid deasserting without a handshake SHALL be tolerated, and selection SHALL re-evaluate every cycle.

Reset
REQ-026 While rst_n=0: state=EMPTY, core_valid=0, core_opcode=0, core_is_vector=0, core_src_id=0, err_illegal=0, rr_ptr=0, and all counters=0.
REQ-027 Reset asserted mid-transfer SHALL discard the held instruction; the first acceptance after reset SHALL use rr_ptr=0.

Configuration
REQ-028 With macro SHADER_INSTR_ARB_STATS_EN defined, the block SHALL add:
- input cnt_clr (1 bit);
- output grant_cnt (NUM_REQ x 16): per-requester count of legal instructions accepted by the core (core_valid and core_ready), saturating at 16'hFFFF;
- cnt_clr=1 SHALL synchronously zero all counters, taking priority over a same-cycle increment.
REQ-029 Without SHADER_INSTR_ARB_STATS_EN, these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-030 Package shader_pkg SHALL hold: the opcode enum (OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_MAC=3), the arbiter FSM state enum, OP_MAX=3, and the counter width CNT_W=16.
REQ-031 The round-robin picker SHALL be sub-module shader_rr_pick: combinational, with inputs req vector and ptr, and outputs one-hot grant, index and any.

Verification
REQ-032 Check reset outputs: assert rst_n=0, then release -> all outputs 0 and req_ready=0.
REQ-033 Check round-robin rotation and full throughput: all 4 req_valid=1, core_ready=1 -> core_src_id sequence 0,1,2,3,0 on consecutive cycles, with core_valid continuously 1.
REQ-034 Check backpressure: req0 opcode=3 (MAC) vector=1 accepted, then core_ready=0 for 5 cycles -> core_opcode=3, core_is_vector=1, core_src_id=0 held stable, req_ready=0000; core_ready=1 -> next grant goes to req1.
REQ-035 Check illegal-opcode handling: req2 sends opcode=9 -> req_ready[2]=1, err_illegal pulses 1 cycle later, core_valid stays 0, and the next grant starts search at index 3.
REQ-036 Check rr_ptr wrap and sparse requests: with only req3 and req1 valid and rr_ptr=2 -> grant order 3, then 1.
REQ-037 Check mid-transfer reset and counters: reset while FULL -> core_valid=0 asynchronously. With SHADER_INSTR_ARB_STATS_EN, 3 req0 handshakes -> grant_cnt[0]=3; then cnt_clr=1 during a handshake -> grant_cnt[0]=0.
